// File: rtl/c1_bus_slave.sv
// ---------------------------------------------------------------------------
// c1_bus_slave
//
// Cache-side front end of bus 1. Decodes the CPU's two-cycle command/address
// phase on the shared A1/D1/C1 bus, hands one request per transaction to the
// cache core over a valid/ready interface, then drives the RESPONSE phase
// back onto the tri-state bus and waits for the CPU to reclaim it.
//
// Ports:
//   CLK, RESET_N        clock (posedge) and asynchronous active-low reset
//   A1   (inout)        bus address, only ever read
//   D1   (inout)        bus data, driven only in read response cycles
//   C1   (inout)        bus command, driven (=7 RESPONSE) only in response cycles
//   req_valid/req_ready request handshake towards the cache core
//   req_cmd             latched command code
//   req_addr            {tag_set, offset}
//   req_wdata           {hi16, lo16} write data
//   rsp_valid/rsp_rdata one-cycle response strobe and read data from the core
//
// Optional build macro C1_STATS_EN adds stat_reads, stat_writes and
// stat_max_wait counters; without it those ports do not exist.
// ---------------------------------------------------------------------------
module c1_bus_slave #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int CACHE_OFFSET_SIZE = 4
) (
    input  logic                                      CLK,
    input  logic                                      RESET_N,
    inout  wire  [ADDR1_BUS_SIZE-1:0]                 A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]                 D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]                  C1,
    output logic                                      req_valid,
    input  logic                                      req_ready,
    output logic [2:0]                                req_cmd,
    output logic [ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr,
    output logic [31:0]                               req_wdata,
    input  logic                                      rsp_valid,
    input  logic [31:0]                               rsp_rdata
`ifdef C1_STATS_EN
    ,
    output logic [31:0]                               stat_reads,
    output logic [31:0]                               stat_writes,
    output logic [15:0]                               stat_max_wait
`endif
);

    localparam logic [2:0] CMD_READ8   = 3'd1;
    localparam logic [2:0] CMD_READ32  = 3'd3;
    localparam logic [2:0] CMD_WRITE8  = 3'd5;
    localparam logic [2:0] CMD_WRITE32 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR2, ST_REQ, ST_WAIT, ST_RESP0, ST_RESP1, ST_RELEASE
    } state_t;

    state_t                        state_q;
    logic [2:0]                    cmd_q;
    logic [ADDR1_BUS_SIZE-1:0]     tag_set_q;
    logic [CACHE_OFFSET_SIZE-1:0]  offset_q;
    logic [31:0]                   wdata_q;
    logic [15:0]                   rdata_hi_q;
    logic                          c1_oe_q;
    logic                          d1_oe_q;
    logic [DATA1_BUS_SIZE-1:0]     d1_out_q;

    // A command is only decoded from a fully resolved, non-zero C1 value.
    logic c1_known;
    logic c1_cmd_ok;
    logic c1_is_nop;
    logic is_read;

    assign c1_known  = !$isunknown(C1);
    assign c1_cmd_ok = c1_known && (C1 != '0);
    assign c1_is_nop = c1_known && (C1 == '0);
    assign is_read   = (cmd_q >= CMD_READ8) && (cmd_q <= CMD_READ32);

    assign req_cmd   = cmd_q;
    assign req_addr  = {tag_set_q, offset_q};
    assign req_wdata = wdata_q;

    // Bus drivers come straight from registers so they release at once on reset.
    assign C1 = c1_oe_q ? CTR1_BUS_SIZE'(CMD_WRITE32) : {CTR1_BUS_SIZE{1'bz}};
    assign D1 = d1_oe_q ? d1_out_q : {DATA1_BUS_SIZE{1'bz}};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            req_valid  <= 1'b0;
            cmd_q      <= '0;
            tag_set_q  <= '0;
            offset_q   <= '0;
            wdata_q    <= '0;
            rdata_hi_q <= '0;
            c1_oe_q    <= 1'b0;
            d1_oe_q    <= 1'b0;
            d1_out_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (c1_cmd_ok) begin
                        cmd_q          <= C1[2:0];
                        tag_set_q      <= A1;
                        wdata_q[15:0]  <= D1;
                        state_q        <= ST_ADDR2;
                    end
                end
                ST_ADDR2: begin
                    offset_q <= A1[CACHE_OFFSET_SIZE-1:0];
                    wdata_q[31:16] <= (cmd_q == CMD_WRITE32) ? D1 : 16'h0000;
                    if (cmd_q == CMD_WRITE8) begin
                        wdata_q[15:8] <= 8'h00;
                    end
                    req_valid <= 1'b1;
                    state_q   <= ST_REQ;
                end
                ST_REQ: begin
                    // rsp_valid here is deliberately ignored: the earliest
                    // legal response is the cycle after the handshake.
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        rdata_hi_q <= rsp_rdata[31:16];
                        c1_oe_q    <= 1'b1;
                        d1_oe_q    <= is_read;
                        d1_out_q   <= (cmd_q == CMD_READ8) ? {8'h00, rsp_rdata[7:0]}
                                                           : rsp_rdata[15:0];
                        state_q    <= ST_RESP0;
                    end
                end
                ST_RESP0: begin
                    if (cmd_q == CMD_READ32) begin
                        d1_out_q <= rdata_hi_q;
                        state_q  <= ST_RESP1;
                    end else begin
                        c1_oe_q <= 1'b0;
                        d1_oe_q <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RESP1: begin
                    c1_oe_q <= 1'b0;
                    d1_oe_q <= 1'b0;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Wait for an explicit NOP so a trailing RESPONSE or a
                    // floating bus is never decoded as a fresh WRITE32.
                    if (c1_is_nop) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef C1_STATS_EN
    logic        handshake;
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_inc;

    assign handshake = (state_q == ST_REQ) && req_ready;
    assign wait_inc  = (wait_cnt_q == 16'hFFFF) ? 16'hFFFF : wait_cnt_q + 16'd1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_reads    <= '0;
            stat_writes   <= '0;
            stat_max_wait <= '0;
            wait_cnt_q    <= '0;
        end else begin
            if (handshake) begin
                wait_cnt_q <= '0;
                if (is_read) begin
                    stat_reads <= stat_reads + 32'd1;
                end
                if (cmd_q >= CMD_WRITE8) begin
                    stat_writes <= stat_writes + 32'd1;
                end
            end
            // wait_inc counts the edge on which rsp_valid is sampled too.
            if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_inc;
                if (rsp_valid && (wait_inc > stat_max_wait)) begin
                    stat_max_wait <= wait_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_c1_bus_slave.sv
module tb_c1_bus_slave;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int OW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    wire  [AW-1:0] A1;
    wire  [DW-1:0] D1;
    wire  [CW-1:0] C1;
    logic [AW-1:0] a1_drv;
    logic [DW-1:0] d1_drv;
    logic          d1_en;
    logic [CW-1:0] c1_drv;
    logic          c1_en;

    assign A1 = a1_drv;
    assign D1 = d1_en ? d1_drv : {DW{1'bz}};
    assign C1 = c1_en ? c1_drv : {CW{1'bz}};

    logic              req_valid, req_ready, rsp_valid;
    logic [2:0]        req_cmd;
    logic [AW+OW-1:0]  req_addr;
    logic [31:0]       req_wdata, rsp_rdata;
`ifdef C1_STATS_EN
    logic [31:0] stat_reads, stat_writes;
    logic [15:0] stat_max_wait;
`endif

    c1_bus_slave dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .A1        (A1),
        .D1        (D1),
        .C1        (C1),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
`ifdef C1_STATS_EN
        ,
        .stat_reads    (stat_reads),
        .stat_writes   (stat_writes),
        .stat_max_wait (stat_max_wait)
`endif
    );

    typedef struct packed {
        logic [2:0]       cmd;
        logic [AW+OW-1:0] addr;
        logic [31:0]      wdata;
    } req_t;

    req_t        req_q[$];
    logic [15:0] beat_q[$];
    req_t        mon_e;
    logic [15:0] mon_b;
    int          checks = 0;
    int          passes = 0;
    int unsigned m_reads = 0, m_writes = 0, m_maxwait = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endfunction

    // Monitor: bus levels, request payloads and response beats.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (c1_en) chk("c1_bus_level", 32'(C1), 32'(c1_drv));
            if (d1_en) chk("d1_bus_level", 32'(D1), 32'(d1_drv));
            if (req_valid === 1'b1) begin
                chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    mon_e = req_q[0];
                    chk("req_cmd", 32'(req_cmd), 32'(mon_e.cmd));
                    chk("req_addr", 32'(req_addr), 32'(mon_e.addr));
                    chk("req_wdata", req_wdata, mon_e.wdata);
                    if (req_ready) void'(req_q.pop_front());
                end
            end
            if (!c1_en && C1 === 3'd7) begin
                chk("rsp_expected", 32'(beat_q.size() != 0), 32'd1);
                if (beat_q.size() != 0) begin
                    mon_b = beat_q.pop_front();
                    chk("rsp_d1", 32'(D1), 32'(mon_b));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_wdata(logic [2:0] cmd, logic [15:0] lo, logic [15:0] hi);
        case (cmd)
            3'd5:    return {16'h0000, 8'h00, lo[7:0]};
            3'd7:    return {hi, lo};
            default: return {16'h0000, lo};
        endcase
    endfunction

    // Runs one bus transaction; nwait >= 1 is the WAIT edge on which
    // rsp_valid is sampled; nfloat cycles of fval and nz released cycles
    // follow the response before the CPU drives NOP.
    task automatic txn(input logic [2:0] cmd, input logic [AW-1:0] ts, input logic [OW-1:0] off,
                       input logic [15:0] dlo, input logic [15:0] dhi, input logic [31:0] rd,
                       input int stall, input int nwait, input int nfloat,
                       input logic [2:0] fval, input int nz, input bit spur);
        req_t r;
        bit   rd_cmd;
        r.cmd = cmd; r.addr = {ts, off}; r.wdata = model_wdata(cmd, dlo, dhi);
        rd_cmd = (cmd >= 3'd1 && cmd <= 3'd3);
        req_q.push_back(r);
        $display("txn cmd=%0d addr=%h wdata=%h rdata=%h stall=%0d wait=%0d",
                 cmd, r.addr, r.wdata, rd, stall, nwait);
        c1_en = 1'b1; c1_drv = cmd; a1_drv = ts; d1_en = 1'b1; d1_drv = dlo;
        cyc();
        c1_drv = 3'd0; a1_drv = {11'($urandom), off}; d1_drv = dhi; rsp_valid = spur;
        cyc();
        d1_drv = 16'($urandom);
        for (int i = 0; i < stall; i++) begin
            req_ready = 1'b0; rsp_valid = spur & 1'($urandom); rsp_rdata = $urandom;
            cyc();
        end
        req_ready = 1'b1; rsp_valid = spur; rsp_rdata = ~rd;
        cyc();
        req_ready = 1'b0; rsp_valid = 1'b0;
        if (rd_cmd) m_reads++;
        if (cmd >= 3'd5) m_writes++;
        if (nwait > m_maxwait) m_maxwait = nwait;
        for (int i = 1; i < nwait; i++) cyc();
        case (cmd)
            3'd1: beat_q.push_back({8'h00, rd[7:0]});
            3'd2: beat_q.push_back(rd[15:0]);
            3'd3: begin beat_q.push_back(rd[15:0]); beat_q.push_back(rd[31:16]); end
            default: beat_q.push_back(16'h0000);
        endcase
        c1_en = 1'b0;
        d1_en = !rd_cmd; d1_drv = 16'h0000;
        rsp_valid = 1'b1; rsp_rdata = rd;
        cyc();
        rsp_valid = 1'b0; rsp_rdata = $urandom;
        cyc();
        if (cmd == 3'd3) cyc();
        for (int i = 0; i < nfloat; i++) begin
            c1_en = 1'b1; c1_drv = fval; d1_en = 1'b1; d1_drv = 16'($urandom);
            cyc();
        end
        for (int i = 0; i < nz; i++) begin
            c1_en = 1'b0; d1_en = 1'b0;
            cyc();
        end
        c1_en = 1'b1; c1_drv = 3'd0; d1_en = 1'b1; d1_drv = 16'($urandom);
        cyc();
        chk("beats_left", beat_q.size(), 32'd0);
        chk("reqs_left", req_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        c1_en = 1'b1; c1_drv = 3'd0; d1_en = 1'b1; d1_drv = 16'h0; a1_drv = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        #1;
        chk("reset_req_valid", 32'(req_valid), 32'd0);
        chk("reset_req_cmd", 32'(req_cmd), 32'd0);
        chk("reset_req_addr", 32'(req_addr), 32'd0);
        chk("reset_req_wdata", req_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Directed cases.
        txn(3'd1, 15'h0123, 4'h5, 16'h1111, 16'h2222, 32'hAABBCCDD, 0, 1, 0, 3'd0, 2, 1'b0);
        txn(3'd3, 15'h7FFF, 4'hF, 16'h0F0F, 16'h0000, 32'h12345678, 0, 1, 1, 3'd4, 0, 1'b1);
        txn(3'd7, 15'h0040, 4'h2, 16'hBEEF, 16'hDEAD, 32'h55AA55AA, 0, 1, 0, 3'd0, 0, 1'b0);
        txn(3'd5, 15'h1234, 4'h9, 16'hA5C3, 16'h9999, 32'h0000FFFF, 1, 2, 0, 3'd0, 0, 1'b0);
        txn(3'd2, 15'h2AAA, 4'h3, 16'h4321, 16'h8765, 32'hCAFEF00D, 5, 120, 0, 3'd0, 0, 1'b1);
        // Release guard: trailing RESPONSE level held, then float, then NOP.
        txn(3'd4, 15'h3C3C, 4'h1, 16'h7777, 16'h6666, 32'h01020304, 0, 1, 3, 3'd7, 1, 1'b0);
`ifdef C1_STATS_EN
        chk("stat_max_wait", 32'(stat_max_wait), m_maxwait);
`endif

        // Randomized transactions with idle NOP gaps.
        for (int n = 0; n < 40; n++) begin
            txn(3'($urandom_range(1, 7)), 15'($urandom), 4'($urandom), 16'($urandom),
                16'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                $urandom_range(0, 2), 3'($urandom_range(1, 6)), $urandom_range(0, 1),
                1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                a1_drv = 15'($urandom); d1_drv = 16'($urandom);
                cyc();
            end
        end
`ifdef C1_STATS_EN
        chk("stat_reads", stat_reads, m_reads);
        chk("stat_writes", stat_writes, m_writes);
        chk("stat_max_wait_rand", 32'(stat_max_wait), m_maxwait);
`endif

        // Reset while the core is working on a READ16.
        req_q.push_back('{3'd2, {15'h0555, 4'hA}, 32'h0000_1357});
        c1_en = 1'b1; c1_drv = 3'd2; a1_drv = 15'h0555; d1_drv = 16'h1357;
        cyc();
        c1_drv = 3'd0; a1_drv = {11'h0, 4'hA};
        cyc();
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        cyc();
        c1_en = 1'b0; d1_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_req_valid", 32'(req_valid), 32'd0);
        chk("rst_wait_req_cmd", 32'(req_cmd), 32'd0);
        chk("rst_wait_req_addr", 32'(req_addr), 32'd0);
        chk("rst_wait_c1_driven", 32'(C1 === 3'd7), 32'd0);
        req_q.delete(); beat_q.delete();
        m_reads = 0; m_writes = 0; m_maxwait = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
        cyc();
        rsp_valid = 1'b0;
        cyc();
        cyc();
        c1_en = 1'b1; c1_drv = 3'd0; d1_en = 1'b1; d1_drv = 16'h0;
        cyc();
        txn(3'd2, 15'h0ABC, 4'h7, 16'h2468, 16'h1357, 32'h89ABCDEF, 1, 3, 0, 3'd0, 0, 1'b0);
`ifdef C1_STATS_EN
        chk("stat_reads_after_rst", stat_reads, m_reads);
        chk("stat_writes_after_rst", stat_writes, m_writes);
`endif

        repeat (3) cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
